// File: rtl/id_ex_register.sv
// ID/EX pipeline register: carries decode-stage operands and control into EX, counts inserted bubbles.
// Latency: one cycle from id_* to ex_*.
// Backpressure: stall holds every EX-side field; flush overrides stall and loads a bubble.
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_read_data1,
  input  logic [DATA_W-1:0] id_read_data2,
  input  logic [DATA_W-1:0] id_sign_ext_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [1:0]        id_alu_op,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_read_data1,
  output logic [DATA_W-1:0] ex_read_data2,
  output logic [DATA_W-1:0] ex_sign_ext_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [1:0]        ex_alu_op,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] sign_ext_imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    logic              reg_dst;
    logic [1:0]        alu_op;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_t           id_s;
  stage_t           ex_d;
  stage_t           ex_q;
  logic [CNT_W-1:0] bubble_count_d;
  logic [CNT_W-1:0] bubble_count_q;
  logic             bubble;

  // Gather the decode-stage fields into one stage word.
  always_comb begin
    id_s              = '0;
    id_s.valid        = id_valid;
    id_s.pc_plus4     = id_pc_plus4;
    id_s.read_data1   = id_read_data1;
    id_s.read_data2   = id_read_data2;
    id_s.sign_ext_imm = id_sign_ext_imm;
    id_s.rs           = id_rs;
    id_s.rt           = id_rt;
    id_s.rd           = id_rd;
    id_s.reg_write    = id_reg_write;
    id_s.mem_to_reg   = id_mem_to_reg;
    id_s.mem_read     = id_mem_read;
    id_s.mem_write    = id_mem_write;
    id_s.branch       = id_branch;
    id_s.alu_src      = id_alu_src;
    id_s.reg_dst      = id_reg_dst;
    id_s.alu_op       = id_alu_op;
  end

  // Next stage contents with flush > stall > load priority; an invalid load keeps
  // its data but has every control bit cleared so it cannot have side effects.
  always_comb begin
    ex_d           = ex_q;
    bubble         = 1'b0;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      ex_d   = '0;
      bubble = 1'b1;
    end else if (!stall) begin
      ex_d = id_s;
      if (!id_valid) begin
        ex_d.reg_write  = 1'b0;
        ex_d.mem_to_reg = 1'b0;
        ex_d.mem_read   = 1'b0;
        ex_d.mem_write  = 1'b0;
        ex_d.branch     = 1'b0;
        ex_d.alu_src    = 1'b0;
        ex_d.reg_dst    = 1'b0;
        ex_d.alu_op     = 2'b00;
        bubble          = 1'b1;
      end
    end
    // Saturating count so a long-running pipe never reports a wrapped small value.
    if (bubble && (bubble_count_q != CNT_MAX)) begin
      bubble_count_d = bubble_count_q + CNT_ONE;
    end
  end

  // Stage and counter registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_q           <= ex_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid        = ex_q.valid;
  assign ex_pc_plus4     = ex_q.pc_plus4;
  assign ex_read_data1   = ex_q.read_data1;
  assign ex_read_data2   = ex_q.read_data2;
  assign ex_sign_ext_imm = ex_q.sign_ext_imm;
  assign ex_rs           = ex_q.rs;
  assign ex_rt           = ex_q.rt;
  assign ex_rd           = ex_q.rd;
  assign ex_reg_write    = ex_q.reg_write;
  assign ex_mem_to_reg   = ex_q.mem_to_reg;
  assign ex_mem_read     = ex_q.mem_read;
  assign ex_mem_write    = ex_q.mem_write;
  assign ex_branch       = ex_q.branch;
  assign ex_alu_src      = ex_q.alu_src;
  assign ex_reg_dst      = ex_q.reg_dst;
  assign ex_alu_op       = ex_q.alu_op;
  assign bubble_count    = bubble_count_q;

endmodule
